// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end: PC generation, I_Cache request issue and a
//   DEPTH-entry fetch queue between the 1-cycle synchronous I_Cache read port
//   and the ID stage. Redirects from EX flush the queue and kill in-flight reads.
//
// Parameters
//   XLEN      address/instruction width
//   DEPTH     fetch-queue entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   halt                  block new fetches (host loading I_Cache)
//   redirect, redirect_pc EX-stage taken branch/jump and its target
//   imem_req, imem_addr   I_Cache read request and byte address
//   imem_rdata            I_Cache read data, valid the cycle after imem_req
//   deq_valid/ready       head-entry handshake with ID
//   deq_pc, deq_instr     presented PC and instruction word
//
// Configuration
//   FETCH_BYPASS_EN  when defined, a response arriving into an empty queue is
//                    presented to ID combinationally in its arrival cycle.

module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [XLEN-1:0] deq_pc,
    output logic [XLEN-1:0] deq_instr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [XLEN-1:0] q_pc_d    [DEPTH];
    logic [XLEN-1:0] q_instr_q [DEPTH];
    logic [XLEN-1:0] q_instr_d [DEPTH];

    logic [XLEN-1:0] target_pc;
    logic            rsp_valid;
    logic            q_empty;
    logic            bypass;
    logic            valid_int;
    logic            deq_fire;
    logic            deq_from_q;
    logic            enq;
    logic            issue;
    logic [CW:0]     occ;
    logic [XLEN-1:0] pres_pc;
    logic [XLEN-1:0] pres_instr;
    logic            target_lsb_unused;

    // Branch targets are word aligned; the low bits are dropped.
    assign target_pc         = {redirect_pc[XLEN-1:2], 2'b00};
    assign target_lsb_unused = ^redirect_pc[1:0];

    always_comb begin
        // A response landing in a redirect or reset cycle belongs to the old stream.
        rsp_valid = inflight_q & ~redirect & ~reset;
        q_empty   = (count_q == '0);
`ifdef FETCH_BYPASS_EN
        bypass    = rsp_valid & q_empty;
`else
        bypass    = 1'b0;
`endif
        valid_int  = ~reset & ~redirect & (~q_empty | bypass);
        deq_fire   = valid_int & deq_ready;
        deq_from_q = deq_fire & ~bypass;
        enq        = rsp_valid & ~(bypass & deq_ready);

        pres_pc    = bypass ? inflight_pc_q : q_pc_q[head_q];
        pres_instr = bypass ? imem_rdata    : q_instr_q[head_q];

        // Credit: entries held plus the read in flight, less what leaves this cycle.
        occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq_fire};
        issue = ~reset & ~halt & (redirect | (occ < DEPTH_OCC));

        imem_req  = issue;
        imem_addr = redirect ? target_pc : pc_q;

        deq_valid = valid_int;
        deq_pc    = reset ? '0 : (valid_int ? pres_pc    : hold_pc_q);
        deq_instr = reset ? '0 : (valid_int ? pres_instr : hold_instr_q);
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        q_pc_d        = q_pc_q;
        q_instr_d     = q_instr_q;

        if (redirect) begin
            pc_d          = halt ? target_pc : target_pc + XLEN'(4);
            inflight_pc_d = target_pc;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + XLEN'(4);
                inflight_pc_d = pc_q;
            end
            if (enq) begin
                q_pc_d[tail_q]    = inflight_pc_q;
                q_instr_d[tail_q] = imem_rdata;
                tail_d            = tail_q + 1'b1;
            end
            if (deq_from_q) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, deq_from_q};
            if (valid_int) begin
                hold_pc_d    = pres_pc;
                hold_instr_d = pres_instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            hold_pc_q     <= '0;
            hold_instr_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
        end
    end

    // Queue storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        q_pc_q    <= q_pc_d;
        q_instr_q <= q_instr_d;
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata = 32'h0;
    logic        w_deq_valid;
    logic        w_deq_ready = 1'b1;
    logic [31:0] w_deq_pc;
    logic [31:0] w_deq_instr;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pops     = 0;

    always #5 clk = ~clk;

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset(reset), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_instr(deq_instr)
    );

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .reset(reset), .halt(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .deq_valid(w_deq_valid), .deq_ready(w_deq_ready),
        .deq_pc(w_deq_pc), .deq_instr(w_deq_instr)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    // I_Cache model: one-cycle synchronous read.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= instr_of(imem_addr);
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && deq_valid && deq_ready) begin
            pops++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", deq_pc, deq_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (deq_pc !== e.pc || deq_instr !== e.instr) begin
                    n_errors++;
                    $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                             deq_pc, deq_instr, e.pc, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", nm, act, expv);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %b, required %b", nm, act, expv);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.pc    = base + 32'(4 * k);
            e.instr = instr_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b1;
        tick(); tick(); tick(); samp();
        chk1("rst_deq_valid", deq_valid, 1'b0);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk("rst_deq_pc", deq_pc, 32'h0);
        chk("rst_deq_instr", deq_instr, 32'h0);
        chk1("rst_wrap_req", w_imem_req, 1'b0);

        // Streaming from reset, plus wrap-around instance.
        tick(); reset = 1'b0; pops = 0; push_seq(32'h0, 16); samp();
        chk1("t1_req0", imem_req, 1'b1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t4_wrap_addr0", w_imem_addr, 32'hFFFF_FFF8);
        for (int i = 1; i <= 6; i++) begin
            tick(); samp();
            if (i <= 3) begin
                chk("t1_addr", imem_addr, 32'(4 * i));
                chk("t4_wrap_addr", w_imem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            end
            chk1("t1_valid", deq_valid, i >= LAT);
            if (i == LAT) chk("t6_first_instr", deq_instr, 32'h0050_0093);
        end
        tick();
        chk("t1_pops", 32'(pops), 32'(7 - LAT));
        exp_q.delete(); reset = 1'b1; deq_ready = 1'b0; samp(); tick();

        // Fill with ID stalled, then drain.
        tick(); reset = 1'b0; pops = 0; push_seq(32'h0, 16);
        for (int i = 0; i <= 6; i++) begin
            if (i != 0) tick();
            samp();
            if (i < 4) begin
                chk1("t2_req", imem_req, 1'b1);
                chk("t2_addr", imem_addr, 32'(4 * i));
            end else begin
                chk1("t2_credit_block", imem_req, 1'b0);
            end
            if (i == 6) begin
                chk1("t2_full_valid", deq_valid, 1'b1);
                chk("t2_head_pc", deq_pc, 32'h0);
            end
        end
        tick(); deq_ready = 1'b1; samp();
        chk1("t2_resume_req", imem_req, 1'b1);
        chk("t2_resume_addr", imem_addr, 32'h10);
        for (int i = 8; i <= 12; i++) begin tick(); samp(); end
        tick();
        chk("t2_pops", 32'(pops), 32'd6);
        exp_q.delete(); reset = 1'b1; deq_ready = 1'b0; samp(); tick();

        // Redirect with three queued and one in flight.
        tick(); reset = 1'b0; pops = 0; samp();
        for (int i = 1; i <= 3; i++) begin tick(); samp(); end
        tick(); redirect = 1'b1; redirect_pc = 32'h103; samp();
        chk1("t3_redir_valid", deq_valid, 1'b0);
        chk1("t3_redir_req", imem_req, 1'b1);
        chk("t3_redir_addr", imem_addr, 32'h100);
        tick(); redirect = 1'b0; deq_ready = 1'b1; push_seq(32'h100, 16);
        for (int j = 1; j <= 4; j++) begin
            if (j != 1) tick();
            samp();
            chk1("t3_valid", deq_valid, j >= LAT);
            if (j == LAT) chk("t3_pc_first", deq_pc, 32'h100);
            if (j == LAT + 1) chk("t3_pc_second", deq_pc, 32'h104);
        end
        tick();
        chk("t3_pops", 32'(pops), 32'(5 - LAT));
        exp_q.delete(); reset = 1'b1; deq_ready = 1'b0; samp(); tick();

        // Halt with a read in flight, redirect during halt.
        tick(); reset = 1'b0; pops = 0; samp();
        chk1("t5_req0", imem_req, 1'b1);
        chk("t5_addr0", imem_addr, 32'h0);
        tick(); halt = 1'b1; samp();
        chk1("t5_halt_req1", imem_req, 1'b0);
        tick(); samp();
        chk1("t5_halt_req2", imem_req, 1'b0);
        chk1("t5_inflight_enq", deq_valid, 1'b1);
        chk("t5_inflight_pc", deq_pc, 32'h0);
        chk("t5_inflight_instr", deq_instr, 32'h0050_0093);
        tick(); redirect = 1'b1; redirect_pc = 32'h40; samp();
        chk1("t5_redir_req", imem_req, 1'b0);
        chk1("t5_redir_valid", deq_valid, 1'b0);
        tick(); redirect = 1'b0; samp();
        chk1("t5_post_req", imem_req, 1'b0);
        chk1("t5_cleared", deq_valid, 1'b0);
        tick(); halt = 1'b0; deq_ready = 1'b1; push_seq(32'h40, 16); samp();
        chk1("t5_resume_req", imem_req, 1'b1);
        chk("t5_resume_addr", imem_addr, 32'h40);
        for (int i = 0; i < 4; i++) begin tick(); samp(); end
        tick();
        chk("t5_pops", 32'(pops), 32'(5 - LAT));

        // Reset mid-stream.
        reset = 1'b1; samp();
        chk1("t6_rst_valid", deq_valid, 1'b0);
        chk1("t6_rst_req", imem_req, 1'b0);
        chk("t6_rst_pc", deq_pc, 32'h0);
        chk("t6_rst_instr", deq_instr, 32'h0);
        tick(); reset = 1'b0; exp_q.delete(); pops = 0; push_seq(32'h0, 16); samp();
        chk1("t6_post_valid", deq_valid, 1'b0);
        chk1("t6_post_req", imem_req, 1'b1);
        chk("t6_post_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin tick(); samp(); end
        tick();
        chk("t6_pops", 32'(pops), 32'(4 - LAT));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
